led_blink_multi: RTL

Parametrised multi-channel LED driver, the successor to the single fixed 1 Hz blinker. A shared prescaler derives a slow tick from the PLL output clock; each channel independently runs OFF, ON, BLINK (tick-counted half-period) or DIM (clock-rate PWM). Channels are reconfigured at run time through a one-cycle write strobe. The block sits directly behind the internal PLL and drives the board LEDs and debug GPIOs.

---
 rtl/led_blink_pkg.sv | 21 ++
 rtl/led_blink_multi_if.sv | 27 ++
 rtl/led_tick_gen.sv | 34 +++
 rtl/led_blink_multi.sv | 125 ++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared types for the multi-channel LED driver: channel modes and the
// per-channel configuration record.
package led_blink_pkg;

    localparam int unsigned CFG_PERIOD_W = 12;
    localparam int unsigned CFG_PWM_W    = 4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_DIM   = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e                   mode;
        logic [CFG_PERIOD_W-1:0] period;
        logic [CFG_PWM_W-1:0]    duty;
    } ch_cfg_t;

endpackage

// File: rtl/led_blink_multi_if.sv
// Configuration strobe and LED/tick outputs of led_blink_multi.
interface led_blink_multi_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned PERIOD_W = 12,
    parameter int unsigned PWM_W    = 4
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [1:0]          cfg_mode;
    logic [PERIOD_W-1:0] cfg_period;
    logic [PWM_W-1:0]    cfg_duty;
    logic                sync_all;
    logic                tick;
    logic [CHANNELS-1:0] led;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty, sync_all,
        input  tick, led
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty, sync_all,
        output tick, led
    );
endinterface

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one registered tick pulse every DIV clocks.
module led_tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: shared tick prescaler and PWM counter, each
// channel independently OFF / ON / BLINK / DIM, reconfigured by write strobe.
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int unsigned         CLK_HZ       = 78_000_000,
    parameter int unsigned         TICK_HZ      = 1000,
    parameter int unsigned         CHANNELS     = 2,
    parameter int unsigned         PERIOD_W     = CFG_PERIOD_W,
    parameter int unsigned         PWM_W        = CFG_PWM_W,
    parameter int unsigned         RESET_PERIOD = 500,
    parameter logic [CHANNELS-1:0] INIT_LED     = CHANNELS'(2'b10)
) (
    input  logic              CLKOS,
    input  logic              RST,
    led_blink_multi_if.slave  bus
);
    localparam int unsigned DIV      = CLK_HZ / TICK_HZ;
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PWM_LAST = (2 ** PWM_W) - 2;

    localparam ch_cfg_t RESET_CFG = '{
        mode:   MODE_BLINK,
        period: CFG_PERIOD_W'(RESET_PERIOD),
        duty:   '0
    };

    logic                tick_w;
    logic                cfg_valid;
    logic [PWM_W-1:0]    pwm_q, pwm_d;
    logic [CHANNELS-1:0] led_w;

    led_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (CLKOS),
        .rst  (RST),
        .tick (tick_w)
    );

    assign cfg_valid = bus.cfg_we && (32'(bus.cfg_ch) < CHANNELS);

    // Shared PWM counter, period 2^PWM_W-1 so a full-scale duty is always on.
    always_comb begin
        pwm_d = (pwm_q == PWM_W'(PWM_LAST)) ? '0 : pwm_q + PWM_W'(1);
    end

    always_ff @(posedge CLKOS) begin
        if (RST) pwm_q <= '0;
        else     pwm_q <= pwm_d;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ch_cfg_t             cfg_q, cfg_d;
        logic [PERIOD_W-1:0] phase_q, phase_d, phase_last;
        logic                led_q, led_d;
        logic                hit;

        assign hit        = cfg_valid && (bus.cfg_ch == CH_W'(i));
        assign phase_last = (cfg_q.period == '0) ? '0
                          : PERIOD_W'(cfg_q.period - CFG_PERIOD_W'(1));

        // Priority: write, then sync_all, then tick.
        always_comb begin
            cfg_d   = cfg_q;
            phase_d = phase_q;
            led_d   = led_q;
            if (hit) begin
                cfg_d.mode   = mode_e'(bus.cfg_mode);
                cfg_d.period = CFG_PERIOD_W'(bus.cfg_period);
                cfg_d.duty   = CFG_PWM_W'(bus.cfg_duty);
                phase_d      = '0;
                case (cfg_d.mode)
                    MODE_OFF:   led_d = 1'b0;
                    MODE_ON:    led_d = 1'b1;
                    MODE_BLINK: led_d = INIT_LED[i];
                    default:    led_d = (pwm_q < PWM_W'(bus.cfg_duty));
                endcase
            end else begin
                case (cfg_q.mode)
                    MODE_OFF: begin
                        led_d   = 1'b0;
                        phase_d = '0;
                    end
                    MODE_ON: begin
                        led_d   = 1'b1;
                        phase_d = '0;
                    end
                    MODE_DIM: begin
                        led_d   = (pwm_q < PWM_W'(cfg_q.duty));
                        phase_d = '0;
                    end
                    default: begin
                        if (bus.sync_all) begin
                            phase_d = '0;
                            led_d   = INIT_LED[i];
                        end else if (tick_w) begin
                            if (phase_q == phase_last) begin
                                phase_d = '0;
                                led_d   = ~led_q;
                            end else begin
                                phase_d = phase_q + PERIOD_W'(1);
                            end
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge CLKOS) begin
            if (RST) begin
                cfg_q   <= RESET_CFG;
                phase_q <= '0;
                led_q   <= INIT_LED[i];
            end else begin
                cfg_q   <= cfg_d;
                phase_q <= phase_d;
                led_q   <= led_d;
            end
        end

        assign led_w[i] = led_q;
    end

    assign bus.tick = tick_w;
    assign bus.led  = led_w;
endmodule
